// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute unit for the multi-cycle datapath.
//
// Decodes ALUOp/Funct into an operation. Simple operations complete in one
// cycle. Shifts by a non-zero amount and multiplies iterate one bit per
// cycle. A start/busy/done handshake lets the control path stall on these
// long operations.
//
// Parameters:
//   WIDTH  - operand/result width (power of two, >= 8)
//   MUL_EN - 1 enables MUL on ALUOp=11; 0 makes ALUOp=11 illegal
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   operation request, accepted only while idle
//   ALUOp   in   operation class from main control
//   Funct   in   {funct7[5], funct3} of the instruction
//   A, B    in   operands; shift amount is B[log2(WIDTH)-1:0]
//   busy    out  iterative operation in progress
//   done    out  one-cycle pulse, Result/Zero/illegal valid
//   Result  out  registered result, held until the next completion
//   Zero    out  registered (Result == 0)
//   illegal out  unsupported ALUOp/Funct on the last completed operation
module alu_mc #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_MUL,
    OP_ILL
  } op_t;

  state_t           state;
  op_t              op;
  op_t              iterOp;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] quickResult;
  logic [WIDTH-1:0] accStep;
  logic             isShift;
  logic             isIter;

  assign shamt   = B[SW-1:0];
  assign isShift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // A shift by zero has nothing to iterate over, so it takes the
  // single-cycle path along with the arithmetic and logic operations.
  assign isIter  = (isShift && (shamt != '0)) || (op == OP_MUL);

  // Translate the main-control class and the instruction function bits into
  // one internal operation code. Anything unrecognised becomes OP_ILL so the
  // single-cycle path can flag it.
  always_comb begin
    op = OP_ILL;
    case (ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (Funct)
          4'b0000: op = OP_ADD;
          4'b1000: op = OP_SUB;
          4'b0111: op = OP_AND;
          4'b0110: op = OP_OR;
          4'b0100: op = OP_XOR;
          4'b0001: op = OP_SLL;
          4'b0101: op = OP_SRL;
          4'b1101: op = OP_SRA;
          default: op = OP_ILL;
        endcase
      end
      default: op = MUL_EN ? OP_MUL : OP_ILL;
    endcase
  end

  // Results for everything that completes on the accepting edge. A shift
  // that reaches this path has a zero amount, so its result is A unchanged.
  // Illegal requests produce a zero result.
  always_comb begin
    quickResult = '0;
    case (op)
      OP_ADD:  quickResult = A + B;
      OP_SUB:  quickResult = A - B;
      OP_AND:  quickResult = A & B;
      OP_OR:   quickResult = A | B;
      OP_XOR:  quickResult = A ^ B;
      OP_SLL:  quickResult = A;
      OP_SRL:  quickResult = A;
      OP_SRA:  quickResult = A;
      default: quickResult = '0;
    endcase
  end

  // Next value of the accumulator for one iteration step. For shifts the
  // accumulator holds the operand being shifted one bit per cycle. For
  // multiply it holds the running product, and the shifted multiplicand is
  // added whenever the current multiplier bit is set.
  always_comb begin
    accStep = acc;
    case (iterOp)
      OP_SLL:  accStep = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  accStep = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  accStep = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_MUL:  accStep = mplier[0] ? (acc + mcand) : acc;
      default: accStep = acc;
    endcase
  end

  // Control FSM and datapath registers.
  // IDLE accepts a request. A single-cycle operation completes immediately.
  // An iterative operation loads the accumulator and counter and moves to
  // ITER. ITER performs one step per edge and completes on the edge where
  // the counter reaches one. done is cleared every edge unless a completion
  // happens on that edge, so it is always a single-cycle pulse. Back-to-back
  // single-cycle requests keep it high. Requests seen while in ITER are
  // dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      iterOp  <= OP_ADD;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Result  <= '0;
      Zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (isIter) begin
              iterOp <= op;
              busy   <= 1'b1;
              state  <= ITER;
              if (op == OP_MUL) begin
                acc    <= '0;
                mcand  <= A;
                mplier <= B;
                cnt    <= CW'(WIDTH);
              end else begin
                acc <= A;
                cnt <= {1'b0, shamt};
              end
            end else begin
              Result  <= quickResult;
              Zero    <= (quickResult == '0);
              illegal <= (op == OP_ILL);
              done    <= 1'b1;
            end
          end
        end
        ITER: begin
          acc    <= accStep;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Result  <= accStep;
            Zero    <= (accStep == '0);
            illegal <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=64).
//
// The main instance runs with MUL_EN=1. A second instance with MUL_EN=0
// shares the operand inputs but has its own start input. Expected results
// come from a behavioural reference model. They are queued when a request
// is issued and popped when the unit signals done.
module tb_alu_mc;

  localparam int WIDTH = 64;

  typedef struct {
    logic [63:0] result;
    logic        zero;
    logic        illegal;
    int          latency;
  } expT;

  logic             clk;
  logic             rst;
  logic             start;
  logic             start2;
  logic [1:0]       ALUOp;
  logic [3:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             illegal;
  logic             busy2;
  logic             done2;
  logic [WIDTH-1:0] Result2;
  logic             Zero2;
  logic             illegal2;

  int totalCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int doneCount  = 0;

  expT sb[$];

  alu_mc #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUOp(ALUOp), .Funct(Funct),
    .A(A), .B(B), .busy(busy), .done(done), .Result(Result),
    .Zero(Zero), .illegal(illegal)
  );

  alu_mc #(.WIDTH(WIDTH), .MUL_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ALUOp(ALUOp), .Funct(Funct),
    .A(A), .B(B), .busy(busy2), .done(done2), .Result(Result2),
    .Zero(Zero2), .illegal(illegal2)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every done pulse of the main unit so that spurious or missing
  // completions can be detected over a window.
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  // Safety net in case the sequence below stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural reference: full-width operators, not iteration.
  function automatic expT refModel(input logic [1:0] op, input logic [3:0] f,
                                   input logic [63:0] a, input logic [63:0] b);
    expT e;
    int  sh;
    sh        = int'(b[5:0]);
    e.result  = '0;
    e.illegal = 1'b0;
    e.latency = 0;
    case (op)
      2'b00: e.result = a + b;
      2'b01: e.result = a - b;
      2'b10: begin
        case (f)
          4'b0000: e.result = a + b;
          4'b1000: e.result = a - b;
          4'b0111: e.result = a & b;
          4'b0110: e.result = a | b;
          4'b0100: e.result = a ^ b;
          4'b0001: begin e.result = a << sh; e.latency = sh; end
          4'b0101: begin e.result = a >> sh; e.latency = sh; end
          4'b1101: begin e.result = 64'($signed(a) >>> sh); e.latency = sh; end
          default: e.illegal = 1'b1;
        endcase
      end
      default: begin e.result = a * b; e.latency = 64; end
    endcase
    e.zero = (e.result == 64'd0);
    return e;
  endfunction

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkValue(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Drives one request for a single cycle and
  // queues its expected outcome. Returns at the falling edge just after
  // the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] f,
                               input logic [63:0] a, input logic [63:0] b);
    ALUOp = op;
    Funct = f;
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(refModel(op, f, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pops the oldest expectation and waits (bounded) for done. Compares
  // busy at entry, completion latency in edges after the accepting edge,
  // and the result flags. startLat is the number of edges already elapsed
  // since the accepting edge.
  task automatic checkOutput(input string tag, input int startLat);
    expT e;
    int  lat;
    if (sb.size() == 0) begin
      checkValue({tag, "_queue"}, 64'(sb.size()), 64'd1);
      return;
    end
    e   = sb.pop_front();
    lat = startLat;
    checkValue({tag, "_busy"}, 64'(busy), 64'(lat < e.latency));
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkValue({tag, "_done"}, 64'(done), 64'd1);
    checkValue({tag, "_latency"}, 64'(lat), 64'(e.latency));
    checkValue({tag, "_result"}, Result, e.result);
    checkValue({tag, "_zero"}, 64'(Zero), 64'(e.zero));
    checkValue({tag, "_illegal"}, 64'(illegal), 64'(e.illegal));
  endtask

  // Directed table of additional operations.
  logic [1:0]  tOp [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10};
  logic [3:0]  tF  [7] = '{4'b0001, 4'b0101, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic [63:0] tA  [7] = '{64'h1, 64'hF0, 64'hA0A0, 64'hFF00, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'h0, 64'h7};
  logic [63:0] tB  [7] = '{64'h5, 64'h104, 64'h0505, 64'h0FF0, 64'h1, 64'h1, 64'h9};

  initial begin
    int base;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    ALUOp  = 2'b00;
    Funct  = 4'b0000;
    A      = '0;
    B      = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkValue("rst_busy", 64'(busy), 64'd0);
    checkValue("rst_done", 64'(done), 64'd0);
    checkValue("rst_result", Result, 64'd0);
    checkValue("rst_zero", 64'(Zero), 64'd0);
    checkValue("rst_illegal", 64'(illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // SUB 5-5 through the R-type decode: single cycle, zero result.
    applyStimulus(2'b10, 4'b1000, 64'd5, 64'd5);
    checkOutput("sub", 0);
    @(negedge clk);
    checkValue("sub_done_pulse", 64'(done), 64'd0);

    // SRA by 4 of the sign bit.
    applyStimulus(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4);
    checkOutput("sra", 0);
    checkValue("sra_const", Result, 64'hF800_0000_0000_0000);
    @(negedge clk);

    // MUL with ignored start pulses and changing operands while busy.
    #1 base = doneCount;
    applyStimulus(2'b11, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    for (int i = 0; i < 3; i++) begin
      ALUOp = 2'b00;
      A     = 64'($urandom);
      B     = 64'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("mul", 3);
    checkValue("mul_const", Result, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (10) @(negedge clk);
    #1 checkValue("mul_one_done", 64'(doneCount - base), 64'd1);
    checkValue("mul_hold", Result, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);

    // Illegal R-type function code.
    applyStimulus(2'b10, 4'b0011, 64'h1234, 64'h5678);
    checkOutput("illfunct", 0);
    checkValue("illfunct_const", Result, 64'd0);
    @(negedge clk);

    // MUL disabled: ALUOp=11 is illegal on the second instance.
    ALUOp  = 2'b11;
    Funct  = 4'b0000;
    A      = 64'd3;
    B      = 64'd5;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkValue("nomul_busy", 64'(busy2), 64'd0);
    checkValue("nomul_done", 64'(done2), 64'd1);
    checkValue("nomul_illegal", 64'(illegal2), 64'd1);
    checkValue("nomul_result", Result2, 64'd0);
    checkValue("nomul_zero", 64'(Zero2), 64'd1);
    @(negedge clk);

    // Back-to-back single-cycle ops: done stays high for two cycles.
    applyStimulus(2'b00, 4'b0000, 64'd1, 64'd2);
    checkOutput("b2b_add", 0);
    applyStimulus(2'b10, 4'b0111, 64'hF0, 64'h3C);
    checkOutput("b2b_and", 0);
    checkValue("b2b_and_const", Result, 64'h30);
    @(negedge clk);
    checkValue("b2b_done_drop", 64'(done), 64'd0);

    // Further patterns, including shift amounts taken from B's low bits only.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tOp[i], tF[i], tA[i], tB[i]);
      checkOutput($sformatf("tab%0d", i), 0);
    end
    @(negedge clk);

    // SLL by zero completes in one cycle with Result = A.
    applyStimulus(2'b10, 4'b0001, 64'h1234, 64'h0);
    checkOutput("sll0", 0);
    checkValue("sll0_const", Result, 64'h1234);
    @(negedge clk);

    // Reset in the middle of a multiply: no done, outputs cleared.
    applyStimulus(2'b11, 4'b0000, 64'h55, 64'h77);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkValue("abort_busy", 64'(busy), 64'd0);
    checkValue("abort_done", 64'(done), 64'd0);
    checkValue("abort_result", Result, 64'd0);
    checkValue("abort_zero", 64'(Zero), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    #1 base = doneCount;
    repeat (80) @(negedge clk);
    #1 checkValue("abort_no_done", 64'(doneCount - base), 64'd0);
    checkValue("abort_result_hold", Result, 64'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
